// File: rtl/audio_mixer_pkg.sv
// Shared types and arithmetic for the audio mixer: FSM states, accumulator
// width, saturation bounds and the per-source gain term.
package audio_mixer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC_OPL,
    ACC_TANDY,
    ACC_SPK,
    SAT
  } state_t;

  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd32768;

  // (src * gain) >>> 2 with gain zero-extended; 4 is unity, 0 mutes the source.
  function automatic logic signed [ACC_W-1:0] gain_term(
    input logic signed [15:0] src,
    input logic        [2:0]  gain
  );
    logic signed [18:0] prod;
    prod = $signed({{3{src[15]}}, src}) * $signed({16'd0, gain});
    return ACC_W'(prod >>> 2);
  endfunction

endpackage

// File: rtl/audio_mixer_spk_lowpass.sv
// One-pole low-pass that turns the 1-bit PC-speaker signal into a smooth
// 16-bit signed level between 0 and SPK_LEVEL.
module spk_lowpass #(
  parameter logic signed [15:0] SPK_LEVEL = 16'sd8192,
  parameter int                 SPK_SHIFT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               speaker_in,
  output logic signed [15:0] level
);

  logic signed [17:0] acc;
  logic signed [17:0] target;
  logic signed [17:0] step;

  assign target = speaker_in ? {{2{SPK_LEVEL[15]}}, SPK_LEVEL} : 18'sd0;
  // Arithmetic shift floors toward -inf, so the falling edge settles at exactly 0.
  assign step   = (target - acc) >>> SPK_SHIFT;
  assign level  = acc[15:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc + step;
  end

endmodule

// File: rtl/audio_mixer.sv
// Mixes PC-speaker, OPL2 and Tandy audio into one saturated signed 16-bit
// sample per SAMPLE_DIV clocks, accumulating one source per clock.
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter logic        [15:0] SAMPLE_DIV = 16'd298,
  parameter logic signed [15:0] SPK_LEVEL  = 16'sd8192,
  parameter int                 SPK_SHIFT  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        speaker_in,
  input  logic [15:0] opl_in,
  input  logic [7:0]  tandy_in,
  input  logic [2:0]  opl_gain,
  input  logic [2:0]  tandy_gain,
  input  logic [2:0]  spk_gain,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        clip
);

  // The accumulate sequence needs 5 clocks, so ticks must be at least that far apart.
  if (SAMPLE_DIV < 16'd5) begin : g_div_check
    $error("audio_mixer: SAMPLE_DIV must be >= 5");
  end

  logic signed [15:0] spk_level;

  spk_lowpass #(
    .SPK_LEVEL (SPK_LEVEL),
    .SPK_SHIFT (SPK_SHIFT)
  ) u_spk (
    .clock      (clock),
    .reset      (reset),
    .speaker_in (speaker_in),
    .level      (spk_level)
  );

  logic [15:0] count;
  logic        tick;

  assign tick = (count == SAMPLE_DIV - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 16'd1;
  end

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [15:0]       opl_s;
  logic signed [15:0]       tandy_s;
  logic signed [15:0]       spk_s;
  logic [2:0]               opl_g;
  logic [2:0]               tandy_g;
  logic [2:0]               spk_g;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      opl_s        <= '0;
      tandy_s      <= '0;
      spk_s        <= '0;
      opl_g        <= '0;
      tandy_g      <= '0;
      spk_g        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            // Freeze every input so later changes cannot leak into this sample.
            opl_s   <= $signed(opl_in);
            tandy_s <= $signed({3'b000, tandy_in, 5'b00000});
            spk_s   <= spk_level;
            opl_g   <= opl_gain;
            tandy_g <= tandy_gain;
            spk_g   <= spk_gain;
            acc     <= '0;
            state   <= ACC_OPL;
          end
        end
        ACC_OPL: begin
          acc   <= acc + gain_term(opl_s, opl_g);
          state <= ACC_TANDY;
        end
        ACC_TANDY: begin
          acc   <= acc + gain_term(tandy_s, tandy_g);
          state <= ACC_SPK;
        end
        ACC_SPK: begin
          acc   <= acc + gain_term(spk_s, spk_g);
          state <= SAT;
        end
        SAT: begin
          sample_valid <= 1'b1;
          state        <= IDLE;
          if (mute) begin
            sample_out <= '0;
            clip       <= 1'b0;
          end else if (acc > SAT_MAX) begin
            sample_out <= 16'h7FFF;
            clip       <= 1'b1;
          end else if (acc < SAT_MIN) begin
            sample_out <= 16'h8000;
            clip       <= 1'b1;
          end else begin
            sample_out <= acc[15:0];
            clip       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
Downstream consumer of the peripheral block's audio outputs: PC-speaker bit (PIT ch2 AND PPI port B bit 1), OPL2 16-bit signed sound and Tandy SN76489 8-bit unsigned sound. Runs on the peripheral clock. Filters the speaker bit and snapshots all three sources at a fixed sample rate. Applies per-source gain, sums sequentially, saturates, and emits one signed 16-bit sample with a valid strobe to the top-level audio output.

Parameters:
SAMPLE_DIV, 16'd298, clock cycles per output sample; must be >= 5 (elaboration-time assertion)
SPK_LEVEL, 16'sd8192, speaker "high" target amplitude
SPK_SHIFT, 4, speaker one-pole filter coefficient (2^-SPK_SHIFT)

Ports:
clock  in  1  peripheral clock
reset  in  1  asynchronous, active-high reset
speaker_in  in  1  PC-speaker bit
opl_in  in  16  OPL2 sample, signed
tandy_in  in  8  Tandy sample, unsigned
opl_gain  in  3  OPL gain, unsigned; 4 = unity
tandy_gain  in  3  Tandy gain, unsigned; 4 = unity
spk_gain  in  3  speaker gain, unsigned; 4 = unity
mute  in  1  forces output samples to zero
sample_out  out  16  mixed sample, signed
sample_valid  out  1  one-cycle strobe when sample_out updates
clip  out  1  set when the last sample saturated; valid with sample_out

Behaviour:
- Reset (async, any time):
  - sample_out=0, sample_valid=0, clip=0.
  - Counter=0, state=IDLE, accumulator=0, speaker filter=0, snapshots=0.
  - Reset mid-sequence aborts the sample; no valid pulse is produced.
- Speaker filter, every clock:
  - target = speaker_in ? SPK_LEVEL : 0.
  - spk_acc (18b signed) <= spk_acc + ((target - spk_acc) >>> SPK_SHIFT), arithmetic shift.
  - Steady state: high → [SPK_LEVEL-15, SPK_LEVEL]; low → exactly 0.
- Timebase:
  - Counter counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (counter == SAMPLE_DIV-1).
  - First tick occurs on edge SAMPLE_DIV after reset release.
- Source conversion:
  - OPL: opl_in as signed.
  - Tandy: {3'b0, tandy_in, 5'b0} (0..8160).
  - Speaker: spk_acc truncated to 16b signed.
- Gain term = (src * gain) >>> 2.
  - src is signed 16b; gain is zero-extended.
  - Product is 19b signed; shift is arithmetic.
  - gain 0 removes the source.
- Accumulator is 20b signed; no internal overflow is possible (max |sum| < 2^18).
- FSM states: IDLE, ACC_OPL, ACC_TANDY, ACC_SPK, SAT. Edges below are relative to the tick edge E0:
  - E0 (IDLE & tick): snapshot all three sources and all three gains; acc<=0; → ACC_OPL.
  - E1: acc += opl term; → ACC_TANDY.
  - E2: acc += tandy term; → ACC_SPK.
  - E3: acc += speaker term; → SAT.
  - E4: sample_out <= clamp(acc, -32768, 32767); clip <= (acc was clamped); sample_valid<=1; → IDLE.
  - E5: sample_valid<=0.
- Latency: 4 clocks from tick edge to valid. Inputs changing after E0 do not affect the current sample.
- Mute (sampled at E4): sample_out=0, clip=0; sample_valid still pulses.
- sample_out and clip hold between strobes.
- A tick outside IDLE cannot occur because SAMPLE_DIV>=5.

Decomposition:
- Package audio_mixer_pkg:
  - state enum (IDLE, ACC_OPL, ACC_TANDY, ACC_SPK, SAT).
  - ACC_W=20, SAT_MAX=20'sd32767, SAT_MIN=-20'sd32768.
  - Shared gain-term function.
- Sub-module spk_lowpass: speaker one-pole filter (clock, reset, speaker_in → 16b signed level), parameterised by SPK_LEVEL and SPK_SHIFT.
- Timebase, FSM and saturation stay in audio_mixer.

Test Plan:
- Reset, all inputs 0, gains 4, SAMPLE_DIV=298 → first sample_valid high exactly on edge 302 for one cycle; sample_out=0, clip=0; next strobe 298 edges later.
- opl_in=1000, opl_gain=4 → 1000; opl_gain=2 → 500; opl_in=-3, opl_gain=1 → -1; opl_gain=0 → 0.
- tandy_in=255, tandy_gain=4, others 0 → 8160; plus opl_in=32767, opl_gain=7 → sample_out=32767, clip=1. opl_in=-32768, opl_gain=7 alone → -32768, clip=1.
- speaker_in=1 for 400 clocks, spk_gain=4 → sample_out in [8177,8192]. Then speaker_in=0 for 400 clocks → 0.
- opl_in=100 at E0, changed to 200 at E2 → sample is 100. mute=1 → sample_out=0, clip=0, valid still pulses.
- Reset asserted at E2 → no valid pulse, all outputs 0. After release, next strobe arrives SAMPLE_DIV+4 edges later with correct value.
